// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin, non-preemptive sharing of one memory port between two cache masters
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              m0_op,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_op,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_op,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              gnt_id,
  output logic              busy,
  output logic              err_timeout
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYC);
  logic [1:0] state, mask, elig;
  logic rr_last, pick;
  logic [CW-1:0] cnt;
  // the just-served master is masked for one IDLE cycle so a late-dropped valid cannot re-grant
  assign elig = {m1_valid, m0_valid} & ~mask;
  assign pick = (elig == 2'b11) ? ~rr_last : elig[1];
  assign mem_valid = state == BUSY;
  assign busy = state != IDLE;
  assign m0_ready = state == DONE && !gnt_id;
  assign m1_ready = state == DONE && gnt_id;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state       <= IDLE;
      mask        <= 2'b00;
      rr_last     <= 1'b1;
      cnt         <= '0;
      gnt_id      <= 1'b0;
      mem_op      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mask <= 2'b00;
          if (|elig) begin
            state     <= BUSY;
            gnt_id    <= pick;
            cnt       <= '0;
            mem_op    <= pick ? m1_op : m0_op;
            mem_addr  <= pick ? m1_addr : m0_addr;
            mem_wdata <= pick ? m1_wdata : m0_wdata;
          end
        end
        BUSY: begin
          if (cnt != LIM) cnt <= cnt + 1'b1;
          if (TIMEOUT_CYC != 0 && cnt == LIM - 1'b1) err_timeout <= 1'b1;
          if (mem_ready) begin
            state   <= DONE;
            rr_last <= gnt_id;
            if (gnt_id) m1_rdata <= mem_rdata;
            else m0_rdata <= mem_rdata;
          end
        end
        DONE: begin
          state <= IDLE;
          mask  <= gnt_id ? 2'b10 : 2'b01;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic vld[2], op[2];
  logic [31:0] addr[2], wd[2];
  logic m0_ready, m1_ready, mem_op, mem_valid, mem_ready, gnt_id, busy, err_timeout;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  int errors = 0, checks = 0;
  bit rand_lat = 0, stray = 0, force_rdy = 0;
  int lat = 0, bcnt = 0, cur = 0;
  logic [31:0] rdval = 32'h0;
  // model: who owns the port, whether memory has answered, who is blocked for one idle cycle
  int own = -1, blk = -1, age = 0;
  bit got = 0, rrl = 1, e_err = 0;
  logic e_op = 1'b0;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0;
  logic [31:0] e_rd[2];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .nrst(nrst),
    .m0_op(op[0]), .m0_valid(vld[0]), .m0_addr(addr[0]), .m0_wdata(wd[0]),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_op(op[1]), .m1_valid(vld[1]), .m1_addr(addr[1]), .m1_wdata(wd[1]),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_op(mem_op), .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .gnt_id(gnt_id), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    int pick;
    bit el0, el1;
    if (!nrst) begin
      own = -1; blk = -1; age = 0; got = 0; rrl = 1; e_err = 0;
      e_op = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_rd[0] = 32'h0; e_rd[1] = 32'h0;
    end else if (own < 0) begin
      el0 = vld[0] && blk != 0;
      el1 = vld[1] && blk != 1;
      pick = (el0 && el1) ? (rrl ? 0 : 1) : el0 ? 0 : el1 ? 1 : -1;
      blk = -1;
      if (pick >= 0) begin
        own = pick; age = 0;
        e_op = op[pick]; e_addr = addr[pick]; e_wdata = wd[pick];
      end
    end else if (!got) begin
      age++;
      if (TMO != 0 && age == TMO) e_err = 1;
      if (mem_ready) begin
        e_rd[own] = mem_rdata; rrl = own[0]; got = 1;
      end
    end else begin
      blk = own; own = -1; got = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge nrst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("busy", busy, own >= 0);
    chk("mem_valid", mem_valid, own >= 0 && !got);
    chk("m0_ready", m0_ready, own == 0 && got);
    chk("m1_ready", m1_ready, own == 1 && got);
    chk("m0_rdata", m0_rdata, e_rd[0]);
    chk("m1_rdata", m1_rdata, e_rd[1]);
    chk("err_timeout", err_timeout, e_err);
    if (own >= 0) chk("gnt_id", gnt_id, own[0]);
    if (own >= 0 && !got) begin
      chk("mem_op", mem_op, e_op);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
    end
  end

  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_valid) begin
        if (bcnt == 0) cur = rand_lat ? (($urandom_range(0, 19) == 0) ? 9 : int'($urandom_range(0, 3))) : lat;
        mem_ready = bcnt == cur;
        mem_rdata = rand_lat ? $urandom : (mem_ready ? rdval : 32'hdeadbeef);
        bcnt++;
      end else begin
        bcnt = 0;
        mem_ready = force_rdy || (stray && $urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
    end
  end

  function automatic logic sig(input int which);
    return which == 0 ? m0_ready : which == 1 ? m1_ready : mem_valid;
  endfunction

  task automatic wait_sig(input int which, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sig(which) && n < 60);
    if (!sig(which)) begin
      checks++; errors++;
      $display("FAIL wait_sig %0d: no event within %0d cycles, required one", which, n);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic run_random(input int cycles);
    int dn[2];
    dn[0] = 0; dn[1] = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (vld[i] && (i == 1 ? m1_ready : m0_ready)) dn[i] = $urandom_range(1, 3);
        if (dn[i] > 0) begin
          dn[i]--;
          if (dn[i] == 0) vld[i] = 1'b0;
        end else if (!vld[i] && $urandom_range(0, 2) == 0) begin
          vld[i] = 1'b1;
          op[i] = 1'($urandom_range(0, 1));
          addr[i] = $urandom;
          wd[i] = $urandom;
        end
      end
    end
  endtask

  initial begin
    int n, k;
    int seq[4];
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; op[i] = 1'b0; addr[i] = 32'h0; wd[i] = 32'h0;
    end
    do_reset();
    // single m0 read, memory answers in the 4th busy cycle
    lat = 3; rdval = 32'h11111111;
    @(negedge clk);
    vld[0] = 1'b1; op[0] = 1'b1; addr[0] = 32'h0;
    @(negedge clk);
    chk("t1 mem_valid", mem_valid, 1);
    chk("t1 mem_op", mem_op, 1);
    chk("t1 mem_addr", mem_addr, 0);
    wait_sig(0, n);
    chk("t1 latency", n, 4);
    chk("t1 m0_rdata", m0_rdata, 32'h11111111);
    chk("t1 m1_ready", m1_ready, 0);
    vld[0] = 1'b0;
    @(negedge clk);
    chk("t1 pulse width", m0_ready, 0);
    // simultaneous requests from reset
    do_reset();
    lat = 0;
    @(negedge clk);
    vld[0] = 1'b1; op[0] = 1'b1; addr[0] = 32'h1000;
    vld[1] = 1'b1; op[1] = 1'b0; addr[1] = 32'h10; wd[1] = 32'h11110000;
    wait_sig(0, n);
    chk("t2 m1 not first", m1_ready, 0);
    vld[0] = 1'b0;
    wait_sig(2, n);
    chk("t2 gnt_id", gnt_id, 1);
    chk("t2 mem_op", mem_op, 0);
    chk("t2 mem_addr", mem_addr, 32'h10);
    chk("t2 mem_wdata", mem_wdata, 32'h11110000);
    wait_sig(1, n);
    chk("t2 m1_ready", m1_ready, 1);
    vld[1] = 1'b0;
    // both masters held valid: strict alternation
    do_reset();
    @(negedge clk);
    vld[0] = 1'b1; op[0] = 1'b1; addr[0] = 32'h100;
    vld[1] = 1'b1; op[1] = 1'b1; addr[1] = 32'h200;
    k = 0;
    for (int c = 0; c < 60 && k < 4; c++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        seq[k] = int'(m1_ready);
        k++;
      end
    end
    chk("t3 transactions", k, 4);
    for (int i = 0; i < k; i++) chk($sformatf("t3 grant %0d", i), seq[i], i % 2);
    vld[0] = 1'b0; vld[1] = 1'b0;
    // m1 arrives while m0 is in flight
    do_reset();
    lat = 4;
    @(negedge clk);
    vld[0] = 1'b1; op[0] = 1'b1; addr[0] = 32'h3000;
    wait_sig(2, n);
    vld[1] = 1'b1; op[1] = 1'b1; addr[1] = 32'h2000;
    for (int c = 0; c < 20 && !m0_ready; c++) begin
      @(negedge clk);
      if (mem_valid) chk("t4 addr hold", mem_addr, 32'h3000);
    end
    chk("t4 m0_ready", m0_ready, 1);
    vld[0] = 1'b0;
    wait_sig(2, n);
    chk("t4 m1 grant delay", n, 2);
    chk("t4 mem_addr", mem_addr, 32'h2000);
    chk("t4 gnt_id", gnt_id, 1);
    wait_sig(1, n);
    vld[1] = 1'b0;
    // watchdog: memory withholds ready for 10 busy cycles
    do_reset();
    lat = 10;
    @(negedge clk);
    vld[1] = 1'b1; op[1] = 1'b0; addr[1] = 32'h40; wd[1] = 32'habcd;
    wait_sig(2, n);
    k = 1;
    while (!m1_ready && k < 40) begin
      if (k == 8) chk("t5 err before", err_timeout, 0);
      if (k == 9) chk("t5 err after", err_timeout, 1);
      @(negedge clk);
      k++;
    end
    chk("t5 done cycle", k, 12);
    chk("t5 m1_ready", m1_ready, 1);
    vld[1] = 1'b0;
    @(negedge clk);
    chk("t5 err sticky", err_timeout, 1);
    // asynchronous reset in the middle of a transaction
    lat = 20;
    vld[0] = 1'b1; op[0] = 1'b1; addr[0] = 32'h500;
    wait_sig(2, n);
    repeat (2) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("t6 mem_valid", mem_valid, 0);
    chk("t6 busy", busy, 0);
    chk("t6 m0_ready", m0_ready, 0);
    chk("t6 err_timeout", err_timeout, 0);
    vld[0] = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    force_rdy = 1;
    @(negedge clk);
    force_rdy = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t6 stray m0_ready", m0_ready, 0);
      chk("t6 stray busy", busy, 0);
    end
    // randomized traffic with random latency and stray memory completions
    do_reset();
    rand_lat = 1; stray = 1;
    run_random(3000);
    vld[0] = 1'b0; vld[1] = 1'b0;
    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
